// File: rtl/uart_frame_pkg.sv
// Shared definitions for the UART frame deframer.
//   - state_e     : deframer states
//   - *_DEF       : default sync byte, counter width and mid-frame timeout
//   - chk_add()   : 8-bit wrapping checksum accumulate
package uart_frame_pkg;

  localparam logic [7:0] SYNC_BYTE_DEF = 8'hA5;
  localparam int         CNT_W_DEF     = 16;
  localparam int         TIMEOUT_DEF   = 1280;

  typedef enum logic [2:0] {
    ST_HUNT,
    ST_LEN,
    ST_PAYLOAD,
    ST_CHK,
    ST_FLUSH
  } state_e;

  function automatic logic [7:0] chk_add(input logic [7:0] s, input logic [7:0] b);
    return s + b;
  endfunction

endpackage

// File: rtl/axis_uart_frame_hold.sv
// Hold register plus AXI-Stream output slot for the frame deframer.
// The newest payload byte is parked in the hold register; it only moves to the
// output slot when a later byte pushes it out (tlast=0) or the frame closes
// (tlast=1, tuser=bad), so tlast always lands on a real payload byte.
//   push_i/push_data_i   : new payload byte (caller guarantees slot_free_o)
//   close_i/close_bad_i  : release held byte as the frame's last beat
//   hold_vld_o           : hold register occupied
//   slot_free_o          : output slot empty or draining this cycle
//   tdata_o/tvalid_o/tlast_o/tuser_o/tready_i : output stream
module axis_uart_frame_hold (
  input  logic       clk,
  input  logic       rst,
  input  logic       push_i,
  input  logic [7:0] push_data_i,
  input  logic       close_i,
  input  logic       close_bad_i,
  output logic       hold_vld_o,
  output logic       slot_free_o,
  output logic [7:0] tdata_o,
  output logic       tvalid_o,
  output logic       tlast_o,
  output logic       tuser_o,
  input  logic       tready_i
);

  logic [7:0] hold_q, hold_d;
  logic       hold_vld_q, hold_vld_d;
  logic [7:0] data_q, data_d;
  logic       vld_q, vld_d, last_q, last_d, user_q, user_d;

  assign slot_free_o = !vld_q | tready_i;

  always_comb begin
    hold_d     = hold_q;
    hold_vld_d = hold_vld_q;
    data_d     = data_q;
    vld_d      = vld_q;
    last_d     = last_q;
    user_d     = user_q;
    if (vld_q && tready_i) vld_d = 1'b0;
    if (push_i) begin
      hold_d     = push_data_i;
      hold_vld_d = 1'b1;
      if (hold_vld_q) begin
        vld_d  = 1'b1;
        data_d = hold_q;
        last_d = 1'b0;
        user_d = 1'b0;
      end
    end else if (close_i) begin
      hold_vld_d = 1'b0;
      vld_d      = 1'b1;
      data_d     = hold_q;
      last_d     = 1'b1;
      user_d     = close_bad_i;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      hold_q     <= 8'd0;
      hold_vld_q <= 1'b0;
      data_q     <= 8'd0;
      vld_q      <= 1'b0;
      last_q     <= 1'b0;
      user_q     <= 1'b0;
    end else begin
      hold_q     <= hold_d;
      hold_vld_q <= hold_vld_d;
      data_q     <= data_d;
      vld_q      <= vld_d;
      last_q     <= last_d;
      user_q     <= user_d;
    end
  end

  assign hold_vld_o = hold_vld_q;
  assign tdata_o    = data_q;
  assign tvalid_o   = vld_q;
  assign tlast_o    = last_q;
  assign tuser_o    = user_q;

endmodule

// File: rtl/axis_uart_frame_rx.sv
// Frame deframer behind the UART RX wrapper: hunts for SYNC_BYTE, reads LEN,
// forwards LEN payload bytes as one AXI-Stream packet and checks the trailing
// checksum ((LEN + payload + CHK) mod 256 == 0). Bad frames are flagged with
// o_tuser on the last beat; zero-length frames produce no output.
// Optional mid-frame timeout: define AXIS_UART_FRAME_RX_TIMEOUT_EN.
//   clk, rst (sync, active high)
//   i_tdata/i_tvalid/i_tready           : input byte stream
//   o_tdata/o_tvalid/o_tready/o_tlast/o_tuser : payload packet stream
//   frames_ok/frames_err                : wrapping frame counters
module axis_uart_frame_rx
  import uart_frame_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE      = SYNC_BYTE_DEF,
  parameter int         TIMEOUT_CYCLES = TIMEOUT_DEF,
  parameter int         CNT_W          = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [7:0]       i_tdata,
  input  logic             i_tvalid,
  output logic             i_tready,
  output logic [7:0]       o_tdata,
  output logic             o_tvalid,
  input  logic             o_tready,
  output logic             o_tlast,
  output logic             o_tuser,
  output logic [CNT_W-1:0] frames_ok,
  output logic [CNT_W-1:0] frames_err
);

  state_e           state_q;
  logic [7:0]       sum_q, cnt_q;
  logic [CNT_W-1:0] ok_q, err_q;
  logic             slot_free, hold_vld, acc, push, close, close_bad, tmo;

  always_comb begin
    case (state_q)
      ST_HUNT, ST_LEN:    i_tready = 1'b1;
      ST_PAYLOAD, ST_CHK: i_tready = slot_free;
      default:            i_tready = 1'b0;
    endcase
  end

  assign acc       = i_tvalid & i_tready;
  assign push      = acc & (state_q == ST_PAYLOAD);
  assign close     = (acc & (state_q == ST_CHK)) | ((state_q == ST_FLUSH) & slot_free);
  assign close_bad = (state_q == ST_FLUSH) | (chk_add(sum_q, i_tdata) != 8'd0);

`ifdef AXIS_UART_FRAME_RX_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  logic [TW-1:0] timer_q;

  // Only silent cycles (no byte offered) advance the timer; a byte held off by
  // downstream backpressure is not a stall of the sender.
  always_ff @(posedge clk) begin
    if (rst) timer_q <= '0;
    else if (state_q == ST_HUNT || state_q == ST_FLUSH || acc) timer_q <= '0;
    else if (!i_tvalid) timer_q <= timer_q + TW'(1);
  end

  assign tmo = (state_q inside {ST_LEN, ST_PAYLOAD, ST_CHK}) & !i_tvalid &
               (timer_q == TW'(TIMEOUT_CYCLES - 1));
`else
  localparam int unused_timeout = TIMEOUT_CYCLES;
  assign tmo = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= ST_HUNT;
      sum_q   <= 8'd0;
      cnt_q   <= 8'd0;
      ok_q    <= '0;
      err_q   <= '0;
    end else begin
      case (state_q)
        ST_HUNT: if (acc && i_tdata == SYNC_BYTE) state_q <= ST_LEN;
        ST_LEN: begin
          if (acc) begin
            if (i_tdata == 8'd0) begin
              err_q   <= err_q + CNT_W'(1);
              state_q <= ST_HUNT;
            end else begin
              cnt_q   <= i_tdata;
              sum_q   <= i_tdata;
              state_q <= ST_PAYLOAD;
            end
          end else if (tmo) begin
            err_q   <= err_q + CNT_W'(1);
            state_q <= ST_HUNT;
          end
        end
        ST_PAYLOAD: begin
          if (acc) begin
            sum_q <= chk_add(sum_q, i_tdata);
            cnt_q <= cnt_q - 8'd1;
            if (cnt_q == 8'd1) state_q <= ST_CHK;
          end else if (tmo) begin
            if (hold_vld) state_q <= ST_FLUSH;
            else begin
              err_q   <= err_q + CNT_W'(1);
              state_q <= ST_HUNT;
            end
          end
        end
        ST_CHK: begin
          if (acc) begin
            if (close_bad) err_q <= err_q + CNT_W'(1);
            else           ok_q  <= ok_q + CNT_W'(1);
            state_q <= ST_HUNT;
          end else if (tmo) state_q <= ST_FLUSH;
        end
        ST_FLUSH: begin
          // Counter bumps on the same edge the aborted last beat enters the slot.
          if (slot_free) begin
            err_q   <= err_q + CNT_W'(1);
            state_q <= ST_HUNT;
          end
        end
        default: state_q <= ST_HUNT;
      endcase
    end
  end

  axis_uart_frame_hold u_hold (
    .clk         (clk),
    .rst         (rst),
    .push_i      (push),
    .push_data_i (i_tdata),
    .close_i     (close),
    .close_bad_i (close_bad),
    .hold_vld_o  (hold_vld),
    .slot_free_o (slot_free),
    .tdata_o     (o_tdata),
    .tvalid_o    (o_tvalid),
    .tlast_o     (o_tlast),
    .tuser_o     (o_tuser),
    .tready_i    (o_tready)
  );

  assign frames_ok  = ok_q;
  assign frames_err = err_q;

endmodule

// File: tb/tb_axis_uart_frame_rx.sv
module tb_axis_uart_frame_rx;

  localparam logic [7:0] SYNC = 8'hA5;

  logic        clk = 1'b0;
  logic        rst;
  logic [7:0]  i_tdata;
  logic        i_tvalid, i_tready;
  logic [7:0]  o_tdata;
  logic        o_tvalid, o_tready, o_tlast, o_tuser;
  logic [15:0] frames_ok, frames_err;

  always #5 clk = ~clk;

  axis_uart_frame_rx dut (
    .clk(clk), .rst(rst),
    .i_tdata(i_tdata), .i_tvalid(i_tvalid), .i_tready(i_tready),
    .o_tdata(o_tdata), .o_tvalid(o_tvalid), .o_tready(o_tready),
    .o_tlast(o_tlast), .o_tuser(o_tuser),
    .frames_ok(frames_ok), .frames_err(frames_err)
  );

  typedef struct { logic [7:0] d; logic l; logic u; } beat_t;
  typedef struct {
    int           n_in;
    logic [127:0] in_b;
    int           n_out;
    logic [63:0]  out_b;
    logic [7:0]   out_l;
    logic [7:0]   out_u;
    int           d_ok;
    int           d_err;
  } vec_t;

  int    vectors = 0, miscompares = 0;
  int    exp_ok = 0, exp_err = 0;
  int    rdy_mode = 0;
  beat_t cap_q[$], exp_q[$];

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    vectors++;
    if (act !== exp) begin
      miscompares++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Output monitor: captures transfers and checks that a stalled beat holds still.
  logic  stall_prev = 1'b0;
  beat_t stall_b;
  always @(negedge clk) begin
    if (rst) stall_prev = 1'b0;
    else begin
      if (stall_prev)
        check("hold_stable", {21'd0, o_tvalid, o_tdata, o_tlast, o_tuser},
              {21'd0, 1'b1, stall_b.d, stall_b.l, stall_b.u});
      if (o_tvalid && o_tready) cap_q.push_back('{o_tdata, o_tlast, o_tuser});
      stall_prev = o_tvalid && !o_tready;
      stall_b    = '{o_tdata, o_tlast, o_tuser};
    end
  end

  initial forever begin
    @(posedge clk); #1;
    if (rdy_mode == 1) o_tready = ($urandom_range(0, 3) != 0);
  end

  task automatic send(input logic [7:0] b);
    bit acc = 1'b0;
    i_tdata  = b;
    i_tvalid = 1'b1;
    for (int k = 0; k < 5000 && !acc; k++) begin
      @(negedge clk); acc = i_tready;
      @(posedge clk); #1;
    end
    if (!acc) check("send_timeout", 0, 1);
  endtask

  task automatic idle(input int n);
    i_tvalid = 1'b0;
    repeat (n) begin @(posedge clk); #1; end
  endtask

  // Reference: scan a byte stream by the frame rules and list expected beats.
  function automatic void model(input logic [7:0] s[$]);
    int i = 0;
    int len, sum;
    while (i < s.size()) begin
      if (s[i] != SYNC) begin i++; continue; end
      if (i + 1 >= s.size()) break;
      len = int'(s[i+1]);
      if (len == 0) begin exp_err++; i += 2; continue; end
      if (i + 2 + len >= s.size()) break;
      sum = len + int'(s[i+2+len]);
      for (int j = 0; j < len; j++) sum += int'(s[i+2+j]);
      for (int j = 0; j < len; j++)
        exp_q.push_back('{s[i+2+j], j == len-1, (j == len-1) && (sum % 256 != 0)});
      if (sum % 256 != 0) exp_err++; else exp_ok++;
      i += len + 3;
    end
  endfunction

  task automatic drain_and_compare(input string tag);
    for (int k = 0; k < 4000 && cap_q.size() < exp_q.size(); k++) @(posedge clk);
    repeat (20) @(posedge clk);
    #1;
    check({tag, "_count"}, cap_q.size(), exp_q.size());
    for (int k = 0; k < exp_q.size() && k < cap_q.size(); k++)
      check({tag, "_beat"}, {21'd0, cap_q[k].d, cap_q[k].l, cap_q[k].u},
            {21'd0, exp_q[k].d, exp_q[k].l, exp_q[k].u});
    check({tag, "_frames_ok"},  frames_ok,  exp_ok[15:0]);
    check({tag, "_frames_err"}, frames_err, exp_err[15:0]);
    cap_q.delete();
    exp_q.delete();
  endtask

  vec_t       tv[6];
  logic [7:0] s[$];
  logic [7:0] b, len, sum, chk;
  int         cyc;

  initial begin
    tv[0] = '{6, 128'({8'hA5,8'h03,8'h11,8'h22,8'h33,8'h97}), 3,
              64'({8'h11,8'h22,8'h33}), 8'b001, 8'b000, 1, 0};
    tv[1] = '{6, 128'({8'hA5,8'h03,8'h11,8'h22,8'h33,8'h98}), 3,
              64'({8'h11,8'h22,8'h33}), 8'b001, 8'b001, 0, 1};
    tv[2] = '{7, 128'({8'h00,8'hFF,8'h5A,8'hA5,8'h01,8'h7E,8'h81}), 1,
              64'(8'h7E), 8'b1, 8'b0, 1, 0};
    tv[3] = '{6, 128'({8'hA5,8'h00,8'hA5,8'h01,8'h7E,8'h81}), 1,
              64'(8'h7E), 8'b1, 8'b0, 1, 1};
    tv[4] = '{4, 128'({8'hA5,8'h01,8'hA5,8'h5A}), 1,
              64'(8'hA5), 8'b1, 8'b0, 1, 0};
    tv[5] = '{9, 128'({8'hA5,8'h01,8'h00,8'h00,8'hA5,8'h02,8'h10,8'h20,8'hCE}), 3,
              64'({8'h00,8'h10,8'h20}), 8'b101, 8'b100, 1, 1};

    rst = 1'b1; i_tvalid = 1'b0; i_tdata = 8'd0; o_tready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tvalid", o_tvalid, 0);
    check("rst_tdata", o_tdata, 0);
    check("rst_tlast", o_tlast, 0);
    check("rst_tuser", o_tuser, 0);
    check("rst_ok", frames_ok, 0);
    check("rst_err", frames_err, 0);
    check("rst_itready", i_tready, 1);
    @(posedge clk); #1 rst = 1'b0;

    // Table vectors
    for (int v = 0; v < 6; v++) begin
      for (int k = 0; k < tv[v].n_in; k++) send(tv[v].in_b[8*(tv[v].n_in-1-k) +: 8]);
      idle(1);
      for (int k = 0; k < tv[v].n_out; k++)
        exp_q.push_back('{tv[v].out_b[8*(tv[v].n_out-1-k) +: 8],
                          tv[v].out_l[tv[v].n_out-1-k], tv[v].out_u[tv[v].n_out-1-k]});
      exp_ok  += tv[v].d_ok;
      exp_err += tv[v].d_err;
      drain_and_compare($sformatf("vec%0d", v));
    end

    // Backpressure: 8-byte frame, downstream stalls 50 cycles mid-frame.
    s.delete();
    s = '{8'hA5, 8'h08, 8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08, 8'hD4};
    model(s);
    for (int k = 0; k < 4; k++) send(s[k]);
    o_tready = 1'b0;
    fork
      begin
        for (int k = 4; k < 11; k++) send(s[k]);
        i_tvalid = 1'b0;
      end
      begin
        repeat (50) @(negedge clk);
        check("bp_itready_low", i_tready, 0);
        check("bp_slot_valid", o_tvalid, 1);
        check("bp_slot_data", o_tdata, 8'h01);
        @(posedge clk); #1 o_tready = 1'b1;
      end
    join
    drain_and_compare("bp");

    // Reset mid-frame drops the partial frame and clears the counters.
    send(8'hA5); send(8'h04); send(8'h01); send(8'h02); send(8'h03);
    idle(2);
    rst = 1'b1; idle(2); rst = 1'b0;
    cap_q.delete();
    @(negedge clk);
    check("mid_rst_tvalid", o_tvalid, 0);
    check("mid_rst_ok", frames_ok, 0);
    check("mid_rst_err", frames_err, 0);
    exp_ok = 0; exp_err = 0;
    @(posedge clk); #1;
    s.delete();
    s = '{8'hA5, 8'h03, 8'h11, 8'h22, 8'h33, 8'h97};
    model(s);
    foreach (s[k]) send(s[k]);
    idle(1);
    drain_and_compare("post_rst");

`ifdef AXIS_UART_FRAME_RX_TIMEOUT_EN
    // Timeout: frame stalls after two of four payload bytes.
    send(8'hA5); send(8'h04); send(8'h01); send(8'h02);
    i_tvalid = 1'b0;
    cyc = 0;
    while (cyc < 2000 && cap_q.size() < 2) begin @(posedge clk); cyc++; end
    check("tmo_window", (cyc >= 1270 && cyc <= 1295), 1);
    exp_q.push_back('{8'h01, 1'b0, 1'b0});
    exp_q.push_back('{8'h02, 1'b1, 1'b1});
    exp_err++;
    #1;
    drain_and_compare("tmo");
    s.delete();
    s = '{8'hA5, 8'h01, 8'h7E, 8'h81};
    model(s);
    foreach (s[k]) send(s[k]);
    idle(1);
    drain_and_compare("tmo_next");
`endif

    // Random frame stream with junk, bad checksums, zero lengths and random ready.
    s.delete();
    for (int f = 0; f < 40; f++) begin
      for (int j = $urandom_range(0, 2); j > 0; j--) begin
        b = 8'($urandom);
        if (b == SYNC) b = 8'h00;
        s.push_back(b);
      end
      len = 8'($urandom_range(0, 9));
      s.push_back(SYNC);
      s.push_back(len);
      if (len != 0) begin
        sum = len;
        for (int j = 0; j < int'(len); j++) begin
          b = 8'($urandom);
          s.push_back(b);
          sum = sum + b;
        end
        chk = 8'd0 - sum;
        if ($urandom_range(0, 3) == 0) chk = chk + 8'($urandom_range(1, 255));
        s.push_back(chk);
      end
    end
    model(s);
    rdy_mode = 1;
    foreach (s[k]) begin
      send(s[k]);
      if ($urandom_range(0, 3) == 0) idle($urandom_range(1, 2));
    end
    idle(1);
    drain_and_compare("rand");
    rdy_mode = 0;
    o_tready = 1'b1;

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
